// File: rtl/bram_port_arbiter.sv
// Two-client arbiter in front of the single-port BRAM controller: bounded-tenure
// round-robin selection, one-cycle en/wr strobe, and tagged read-data return.
module bram_port_arbiter #(
   parameter int AW        = 17,
   parameter int DW        = 8,
   parameter int MAX_GRANT = 4
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          r0_req,
   input  logic          r0_wr,
   input  logic [AW-1:0] r0_addr,
   input  logic [DW-1:0] r0_wdata,
   output logic          r0_ack,
   output logic [DW-1:0] r0_rdata,
   output logic          r0_rvalid,
   input  logic          r1_req,
   input  logic          r1_wr,
   input  logic [AW-1:0] r1_addr,
   input  logic [DW-1:0] r1_wdata,
   output logic          r1_ack,
   output logic [DW-1:0] r1_rdata,
   output logic          r1_rvalid,
   output logic          en,
   output logic          wr,
   output logic [AW-1:0] addr_out,
   output logic [DW-1:0] wdata_out,
   input  logic [DW-1:0] rdata_in,
   input  logic          rdata_rdy,
   output logic          err_spur
);

   localparam int CW = (MAX_GRANT < 1) ? 1 : $clog2(MAX_GRANT + 1);
   localparam logic [CW-1:0] MAX_CNT = CW'(MAX_GRANT);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      OWN0 = 2'd1,
      OWN1 = 2'd2
   } state_t;

   state_t        state_r, state_nx_s;
   logic [CW-1:0] cnt_r, cnt_nx_s;
   logic          last_r, last_nx_s;
   logic          rd_pend_r, rd_pend_nx_s;
   logic          rd_tag_r, rd_tag_nx_s;
   logic          err_spur_r, err_spur_nx_s;
   logic          sel_vld_s;
   logic          sel_k_s;
   logic          sel_wr_s;

   function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] c);
      if (c >= MAX_CNT) begin
         return MAX_CNT;
      end else begin
         return c + CW'(1);
      end
   endfunction

   // Pick at most one client per cycle from the current owner and tenure count.
   always_comb begin
      sel_vld_s = 1'b0;
      sel_k_s   = 1'b0;
      case (state_r)
         IDLE: begin
            if (r0_req && r1_req) begin
               sel_vld_s = 1'b1;
               sel_k_s   = ~last_r;
            end else if (r0_req) begin
               sel_vld_s = 1'b1;
               sel_k_s   = 1'b0;
            end else if (r1_req) begin
               sel_vld_s = 1'b1;
               sel_k_s   = 1'b1;
            end else begin
               sel_vld_s = 1'b0;
               sel_k_s   = 1'b0;
            end
         end
         OWN0: begin
            if (r0_req && ((cnt_r < MAX_CNT) || !r1_req)) begin
               sel_vld_s = 1'b1;
               sel_k_s   = 1'b0;
            end else if (r1_req) begin
               sel_vld_s = 1'b1;
               sel_k_s   = 1'b1;
            end else begin
               sel_vld_s = 1'b0;
               sel_k_s   = 1'b0;
            end
         end
         OWN1: begin
            if (r1_req && ((cnt_r < MAX_CNT) || !r0_req)) begin
               sel_vld_s = 1'b1;
               sel_k_s   = 1'b1;
            end else if (r0_req) begin
               sel_vld_s = 1'b1;
               sel_k_s   = 1'b0;
            end else begin
               sel_vld_s = 1'b0;
               sel_k_s   = 1'b0;
            end
         end
         default: begin
            sel_vld_s = 1'b0;
            sel_k_s   = 1'b0;
         end
      endcase
   end

   assign sel_wr_s = sel_k_s ? r1_wr : r0_wr;

   // Drive the controller strobe and the accept of the selected client; quiet in reset.
   always_comb begin
      en        = 1'b0;
      wr        = 1'b0;
      addr_out  = {AW{1'b0}};
      wdata_out = {DW{1'b0}};
      r0_ack    = 1'b0;
      r1_ack    = 1'b0;
      if (rst_n && sel_vld_s) begin
         en        = 1'b1;
         wr        = sel_wr_s;
         addr_out  = sel_k_s ? r1_addr  : r0_addr;
         wdata_out = sel_k_s ? r1_wdata : r0_wdata;
         r0_ack    = ~sel_k_s;
         r1_ack    = sel_k_s;
      end else begin
         en        = 1'b0;
         wr        = 1'b0;
         addr_out  = {AW{1'b0}};
         wdata_out = {DW{1'b0}};
         r0_ack    = 1'b0;
         r1_ack    = 1'b0;
      end
   end

   // Next-state: tenure tracking, read tag bookkeeping and the sticky spurious flag.
   always_comb begin
      state_nx_s    = state_r;
      cnt_nx_s      = cnt_r;
      last_nx_s     = last_r;
      rd_pend_nx_s  = 1'b0;
      rd_tag_nx_s   = rd_tag_r;
      err_spur_nx_s = err_spur_r | (rdata_rdy & ~rd_pend_r);
      if (sel_vld_s) begin
         last_nx_s = sel_k_s;
         if ((state_r == OWN0 && !sel_k_s) || (state_r == OWN1 && sel_k_s)) begin
            state_nx_s = state_r;
            cnt_nx_s   = sat_inc(cnt_r);
         end else begin
            state_nx_s = sel_k_s ? OWN1 : OWN0;
            cnt_nx_s   = CW'(1);
         end
         if (!sel_wr_s) begin
            rd_pend_nx_s = 1'b1;
            rd_tag_nx_s  = sel_k_s;
         end else begin
            rd_pend_nx_s = 1'b0;
            rd_tag_nx_s  = rd_tag_r;
         end
      end else begin
         // An idle cycle ends the current tenure.
         state_nx_s = IDLE;
         cnt_nx_s   = {CW{1'b0}};
      end
   end

   // State registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r    <= IDLE;
         cnt_r      <= {CW{1'b0}};
         last_r     <= 1'b1;
         rd_pend_r  <= 1'b0;
         rd_tag_r   <= 1'b0;
         err_spur_r <= 1'b0;
      end else begin
         state_r    <= state_nx_s;
         cnt_r      <= cnt_nx_s;
         last_r     <= last_nx_s;
         rd_pend_r  <= rd_pend_nx_s;
         rd_tag_r   <= rd_tag_nx_s;
         err_spur_r <= err_spur_nx_s;
      end
   end

   assign r0_rdata  = rdata_in;
   assign r1_rdata  = rdata_in;
   assign r0_rvalid = rst_n & rdata_rdy & rd_pend_r & ~rd_tag_r;
   assign r1_rvalid = rst_n & rdata_rdy & rd_pend_r & rd_tag_r;
   assign err_spur  = err_spur_r;

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Directed self-checking bench for bram_port_arbiter: inputs change on the falling
// edge, outputs are sampled 1 ns later, well away from the rising edge.
module tb_bram_port_arbiter;
   localparam int AW = 17;
   localparam int DW = 8;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          r0_req, r0_wr, r1_req, r1_wr;
   logic [AW-1:0] r0_addr, r1_addr;
   logic [DW-1:0] r0_wdata, r1_wdata;
   logic          r0_ack, r1_ack, r0_rvalid, r1_rvalid;
   logic [DW-1:0] r0_rdata, r1_rdata;
   logic          en, wr, rdata_rdy, err_spur;
   logic [AW-1:0] addr_out;
   logic [DW-1:0] wdata_out, rdata_in;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   bram_port_arbiter #(.AW(AW), .DW(DW), .MAX_GRANT(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .r0_req(r0_req), .r0_wr(r0_wr), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
      .r0_ack(r0_ack), .r0_rdata(r0_rdata), .r0_rvalid(r0_rvalid),
      .r1_req(r1_req), .r1_wr(r1_wr), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
      .r1_ack(r1_ack), .r1_rdata(r1_rdata), .r1_rvalid(r1_rvalid),
      .en(en), .wr(wr), .addr_out(addr_out), .wdata_out(wdata_out),
      .rdata_in(rdata_in), .rdata_rdy(rdata_rdy), .err_spur(err_spur)
   );

   task automatic idle_inputs();
      r0_req = 1'b0; r0_wr = 1'b0; r0_addr = 17'h00000; r0_wdata = 8'h00;
      r1_req = 1'b0; r1_wr = 1'b0; r1_addr = 17'h00000; r1_wdata = 8'h00;
      rdata_rdy = 1'b0; rdata_in = 8'h00;
   endtask

   // Leaves the bench at a falling edge with rst_n just released.
   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      idle_inputs();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      @(negedge clk);
      rst_n = 1'b0;
      idle_inputs();
      r0_req = 1'b1; r1_req = 1'b1; rdata_rdy = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1;
         n_cmp++;
         if ({en, r0_ack, r1_ack, r0_rvalid, r1_rvalid} !== 5'b00000) begin
            $display("FAIL reset_outs cyc%0d: got en/a0/a1/v0/v1=%b want 00000", i,
                     {en, r0_ack, r1_ack, r0_rvalid, r1_rvalid});
            n_err++;
         end
         @(negedge clk);
      end
      #1;
      n_cmp++;
      if (err_spur !== 1'b0) begin
         $display("FAIL reset_err_spur: got %b want 0", err_spur);
         n_err++;
      end
      rst_n = 1'b1;
      rdata_rdy = 1'b0;
      #1;
      n_cmp++;
      if ({r0_ack, r1_ack} !== 2'b10) begin
         $display("FAIL reset_first_tie: got a0a1=%b want 10", {r0_ack, r1_ack});
         n_err++;
      end
   endtask

   task automatic test_contention();
      logic [DW-1:0] rd_val;
      int            exp_k;
      int            prev_k;
      do_reset();
      prev_k = 0;
      for (int i = 0; i <= 12; i++) begin
         rd_val    = 8'h40 + 8'(i);
         r0_req    = (i < 12); r0_wr = 1'b0; r0_addr = 17'h00100;
         r1_req    = (i < 12); r1_wr = 1'b0; r1_addr = 17'h1F000;
         rdata_rdy = (i > 0);
         rdata_in  = rd_val;
         exp_k     = (i / 4) % 2;
         #1;
         if (i < 12) begin
            n_cmp++;
            if ({r0_ack, r1_ack} !== ((exp_k == 0) ? 2'b10 : 2'b01)) begin
               $display("FAIL cont_ack cyc%0d: got a0a1=%b want client %0d", i,
                        {r0_ack, r1_ack}, exp_k);
               n_err++;
            end
            n_cmp++;
            if (addr_out !== ((exp_k == 0) ? 17'h00100 : 17'h1F000) || en !== 1'b1 || wr !== 1'b0) begin
               $display("FAIL cont_strobe cyc%0d: got en=%b wr=%b addr=%h", i, en, wr, addr_out);
               n_err++;
            end
         end else begin
            n_cmp++;
            if (en !== 1'b0) begin
               $display("FAIL cont_tail_en: got %b want 0", en);
               n_err++;
            end
         end
         if (i > 0) begin
            n_cmp++;
            if ({r0_rvalid, r1_rvalid} !== ((prev_k == 0) ? 2'b10 : 2'b01)) begin
               $display("FAIL cont_rvalid cyc%0d: got v0v1=%b want client %0d", i,
                        {r0_rvalid, r1_rvalid}, prev_k);
               n_err++;
            end
            n_cmp++;
            if (((prev_k == 0) ? r0_rdata : r1_rdata) !== rd_val) begin
               $display("FAIL cont_rdata cyc%0d: got %h want %h", i,
                        (prev_k == 0) ? r0_rdata : r1_rdata, rd_val);
               n_err++;
            end
         end else begin
            n_cmp++;
            if ({r0_rvalid, r1_rvalid} !== 2'b00) begin
               $display("FAIL cont_rvalid0: got %b want 00", {r0_rvalid, r1_rvalid});
               n_err++;
            end
         end
         prev_k = exp_k;
         @(negedge clk);
      end
      idle_inputs();
      #1;
      n_cmp++;
      if (err_spur !== 1'b0) begin
         $display("FAIL cont_err_spur: got %b want 0", err_spur);
         n_err++;
      end
   endtask

   task automatic test_lone_requester();
      do_reset();
      for (int i = 0; i < 10; i++) begin
         r1_req = 1'b1; r1_wr = 1'b1; r1_addr = 17'h1FFFF; r1_wdata = 8'hA5;
         r0_req = (i == 5); r0_wr = 1'b1; r0_addr = 17'h00010; r0_wdata = 8'h3C;
         #1;
         n_cmp++;
         if (i == 5) begin
            if ({r0_ack, r1_ack} !== 2'b10 || addr_out !== 17'h00010 || wdata_out !== 8'h3C || en !== 1'b1 || wr !== 1'b1) begin
               $display("FAIL lone_preempt: got a0a1=%b en=%b wr=%b addr=%h wd=%h want a0a1=10 addr=00010 wd=3c",
                        {r0_ack, r1_ack}, en, wr, addr_out, wdata_out);
               n_err++;
            end
         end else begin
            if ({r0_ack, r1_ack} !== 2'b01 || addr_out !== 17'h1FFFF || wdata_out !== 8'hA5 || en !== 1'b1 || wr !== 1'b1) begin
               $display("FAIL lone_r1 cyc%0d: got a0a1=%b en=%b wr=%b addr=%h wd=%h want a0a1=01 addr=1ffff wd=a5",
                        i, {r0_ack, r1_ack}, en, wr, addr_out, wdata_out);
               n_err++;
            end
         end
         @(negedge clk);
      end
      idle_inputs();
   endtask

   task automatic test_idle_gap();
      do_reset();
      for (int i = 0; i < 4; i++) begin
         idle_inputs();
         r0_req = (i < 2) || (i == 3); r0_wr = 1'b1;
         r1_req = (i == 3);            r1_wr = 1'b1;
         #1;
         n_cmp++;
         if (i < 2) begin
            if ({r0_ack, r1_ack} !== 2'b10) begin
               $display("FAIL gap_r0 cyc%0d: got a0a1=%b want 10", i, {r0_ack, r1_ack});
               n_err++;
            end
         end else if (i == 2) begin
            if (en !== 1'b0 || {r0_ack, r1_ack} !== 2'b00) begin
               $display("FAIL gap_idle: got en=%b a0a1=%b want 0 00", en, {r0_ack, r1_ack});
               n_err++;
            end
         end else begin
            if ({r0_ack, r1_ack} !== 2'b01) begin
               $display("FAIL gap_tie: got a0a1=%b want 01", {r0_ack, r1_ack});
               n_err++;
            end
         end
         @(negedge clk);
      end
      idle_inputs();
   endtask

   task automatic test_spurious();
      do_reset();
      rdata_rdy = 1'b1; rdata_in = 8'h77;
      #1;
      n_cmp++;
      if ({r0_rvalid, r1_rvalid, err_spur} !== 3'b000) begin
         $display("FAIL spur_pre: got v0v1err=%b want 000", {r0_rvalid, r1_rvalid, err_spur});
         n_err++;
      end
      @(negedge clk);
      rdata_rdy = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1;
         n_cmp++;
         if (err_spur !== 1'b1) begin
            $display("FAIL spur_sticky cyc%0d: got %b want 1", i, err_spur);
            n_err++;
         end
         @(negedge clk);
      end
      do_reset();
      #1;
      n_cmp++;
      if (err_spur !== 1'b0) begin
         $display("FAIL spur_cleared: got %b want 0", err_spur);
         n_err++;
      end
   endtask

   task automatic test_reset_mid_read();
      do_reset();
      r0_req = 1'b1; r0_wr = 1'b0; r0_addr = 17'h00042;
      #1;
      n_cmp++;
      if (r0_ack !== 1'b1) begin
         $display("FAIL midrd_ack: got %b want 1", r0_ack);
         n_err++;
      end
      @(negedge clk);
      idle_inputs();
      rst_n = 1'b0; rdata_rdy = 1'b1; rdata_in = 8'h99;
      #1;
      n_cmp++;
      if ({r0_rvalid, r1_rvalid} !== 2'b00) begin
         $display("FAIL midrd_rvalid: got v0v1=%b want 00", {r0_rvalid, r1_rvalid});
         n_err++;
      end
      @(negedge clk);
      rst_n = 1'b1; rdata_rdy = 1'b0;
      #1;
      n_cmp++;
      if (err_spur !== 1'b0) begin
         $display("FAIL midrd_err_spur: got %b want 0", err_spur);
         n_err++;
      end
   endtask

   initial begin
      rst_n = 1'b0;
      idle_inputs();
      test_reset();
      test_contention();
      test_lone_requester();
      test_idle_gap();
      test_spurious();
      test_reset_mid_read();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
